// File: rtl/adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// adc_sample_scheduler
//
// Divides the system clock down to the audio sample rate. On every sample tick
// it captures the audio ADC channel as a signed, DC-centred sample and offers
// it downstream over a valid/ready handshake. In the same tick it refreshes one
// potentiometer channel in round-robin order. A sample overwritten before
// acceptance sets a sticky overrun flag.
//
// Optional feature macro: ADC_SCHED_KNOB_SMOOTH_EN
//   When defined, each potentiometer value is low-pass filtered
//   (v += (x - v) >>> 2) after its first post-reset update, which loads the
//   raw value directly.
//
// Ports:
//   CLOCK         in   system clock
//   RESET         in   synchronous, active-high reset
//   EN            in   run enable
//   ADC_CH        in   8*DW   latest ADC results, channel n at [DW*n +: DW]
//   SAMPLE_DATA   out  DW     signed audio sample (two's complement)
//   SAMPLE_VALID  out  1      SAMPLE_DATA valid
//   SAMPLE_READY  in   1      downstream accepts
//   TICK          out  1      one-cycle pulse per sample period
//   KNOB_VALUES   out  NUM_KNOBS*DW  pot k at [DW*k +: DW], unsigned
//   KNOB_UPDATE   out  NUM_KNOBS     one-hot pulse when pot k is written
//   OVERRUN       out  1      sticky: unaccepted sample was overwritten
//   OVERRUN_CLR   in   1      clears OVERRUN (a simultaneous set wins)
// -----------------------------------------------------------------------------
module adc_sample_scheduler #(
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int DW        = 12,
  parameter int AUDIO_CH  = 0,
  parameter int KNOB_BASE = 1,
  parameter int NUM_KNOBS = 4
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic [8*DW-1:0]         ADC_CH,
  output logic [DW-1:0]           SAMPLE_DATA,
  output logic                    SAMPLE_VALID,
  input  logic                    SAMPLE_READY,
  output logic                    TICK,
  output logic [NUM_KNOBS*DW-1:0] KNOB_VALUES,
  output logic [NUM_KNOBS-1:0]    KNOB_UPDATE,
  output logic                    OVERRUN,
  input  logic                    OVERRUN_CLR
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int KW  = (NUM_KNOBS > 1) ? $clog2(NUM_KNOBS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [KW-1:0] PIDX_LAST = KW'(NUM_KNOBS - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DIV < 2) begin : g_chk_div
    $fatal(1, "adc_sample_scheduler: CLK_HZ/SAMPLE_HZ must be >= 2");
  end
  if (NUM_KNOBS < 1) begin : g_chk_npots
    $fatal(1, "adc_sample_scheduler: NUM_KNOBS must be >= 1");
  end
  if (KNOB_BASE + NUM_KNOBS > 8) begin : g_chk_pot_range
    $fatal(1, "adc_sample_scheduler: pot channels exceed ADC channel count");
  end
  if (AUDIO_CH >= 8) begin : g_chk_audio_range
    $fatal(1, "adc_sample_scheduler: AUDIO_CH must be < 8");
  end
  if ((AUDIO_CH >= KNOB_BASE) && (AUDIO_CH < KNOB_BASE + NUM_KNOBS)) begin : g_chk_overlap
    $fatal(1, "adc_sample_scheduler: AUDIO_CH overlaps pot channels");
  end

  // ---------------------------------------------------------------------------
  // Rate FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_tick;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A tick needs EN still high in the terminal-count cycle: dropping EN
  // suppresses any tick that would otherwise land in the exit cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_tick      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EN) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!EN) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tick    = (r_cnt == CNT_LAST);
          w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Audio and potentiometer data path
  // ---------------------------------------------------------------------------
  logic [DW-1:0] w_audio_raw;
  logic [DW-1:0] w_audio_centred;

  assign w_audio_raw     = ADC_CH[DW*AUDIO_CH +: DW];
  // Subtracting 2^(DW-1) from an unsigned code is just an MSB inversion.
  assign w_audio_centred = {~w_audio_raw[DW-1], w_audio_raw[DW-2:0]};

  logic [DW-1:0] r_pot [NUM_KNOBS];
  logic [KW-1:0] r_pidx;
  logic [DW-1:0] w_pot_raw;
  logic [DW-1:0] w_pot_cur;
  logic [DW-1:0] w_pot_new;

  always_comb begin
    w_pot_raw = '0;
    w_pot_cur = '0;
    for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
      if (KW'(i) == r_pidx) begin
        w_pot_raw = ADC_CH[DW*(KNOB_BASE+i) +: DW];
        w_pot_cur = r_pot[i];
      end
    end
  end

`ifdef ADC_SCHED_KNOB_SMOOTH_EN
  logic [NUM_KNOBS-1:0] r_primed;
  logic                 w_primed_cur;
  logic signed [DW:0]   w_diff;
  logic signed [DW:0]   w_sum;

  always_comb begin
    w_primed_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
      if (KW'(i) == r_pidx) w_primed_cur = r_primed[i];
    end
  end

  // One extra bit keeps the difference signed; the result stays within
  // 0..2^DW-1 because it moves at most a quarter of the way toward x.
  assign w_diff    = $signed({1'b0, w_pot_raw}) - $signed({1'b0, w_pot_cur});
  assign w_sum     = $signed({1'b0, w_pot_cur}) + (w_diff >>> 2);
  assign w_pot_new = w_primed_cur ? w_sum[DW-1:0] : w_pot_raw;
`else
  assign w_pot_new = w_pot_raw;
`endif

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [DW-1:0]        r_sample_data;
  logic                 r_sample_valid;
  logic                 r_tick;
  logic [NUM_KNOBS-1:0] r_pot_update;
  logic                 r_overrun;
  logic                 w_overwrite;

  assign w_overwrite = w_tick && r_sample_valid && !SAMPLE_READY;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_tick         <= 1'b0;
      r_pot_update   <= '0;
      r_overrun      <= 1'b0;
      r_pidx         <= '0;
      for (int unsigned i = 0; i < NUM_KNOBS; i++) r_pot[i] <= '0;
`ifdef ADC_SCHED_KNOB_SMOOTH_EN
      r_primed       <= '0;
`endif
    end else begin
      r_tick       <= w_tick;
      r_pot_update <= '0;

      // A tick always loads, so it also covers a transfer in the same cycle.
      if (w_tick) begin
        r_sample_data  <= w_audio_centred;
        r_sample_valid <= 1'b1;
        for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
          if (KW'(i) == r_pidx) begin
            r_pot[i]        <= w_pot_new;
            r_pot_update[i] <= 1'b1;
`ifdef ADC_SCHED_KNOB_SMOOTH_EN
            r_primed[i]     <= 1'b1;
`endif
          end
        end
        r_pidx <= (r_pidx == PIDX_LAST) ? '0 : r_pidx + 1'b1;
      end else if (r_sample_valid && SAMPLE_READY) begin
        r_sample_valid <= 1'b0;
      end

      if (w_overwrite) begin
        r_overrun <= 1'b1;
      end else if (OVERRUN_CLR) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    KNOB_VALUES = '0;
    for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
      KNOB_VALUES[DW*i +: DW] = r_pot[i];
    end
  end

  assign SAMPLE_DATA  = r_sample_data;
  assign SAMPLE_VALID = r_sample_valid;
  assign TICK         = r_tick;
  assign KNOB_UPDATE  = r_pot_update;
  assign OVERRUN      = r_overrun;

  // Channels that are neither audio nor pots are intentionally ignored.
  logic w_unused_adc;
  assign w_unused_adc = ^ADC_CH;

endmodule
